// File: rtl/alu_iter_exec.sv
// alu_iter_exec
//   Execute-stage ALU fed by the ALU controller. Logic, arithmetic and compare
//   ops finish in one cycle. Shifts move one bit per cycle through an
//   accumulator, which avoids a barrel shifter. A valid/ready handshake on both
//   sides holds the pipeline while a shift is in flight.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low
//   flush      kills any in-flight op; takes priority over accept and handshake
//   in_valid   Operation/SrcA/SrcB valid
//   in_ready   an op can be accepted this cycle
//   Operation  4-bit op code
//   SrcA       operand A
//   SrcB       operand B; SrcB[SW-1:0] is the shift amount
//   out_valid  ALUResult valid
//   out_ready  consumer takes the result
//   ALUResult  registered result
//   Zero       ALUResult == 0
//   busy       an op is in flight (state != IDLE)
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | waiting for an op; in_ready unless flushing
// S_SHIFT | shifting acc one bit per cycle; cnt bits remain
// S_DONE  | result held on ALUResult until out_ready
module alu_iter_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  busy
);

  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_t;

  state_t                state_q, state_d;
  kind_t                 kind_q, kind_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [SW-1:0]         cnt_q, cnt_d;

  logic                  accept;
  logic                  is_shift;
  logic [SW-1:0]         shamt;
  logic                  lt_s;
  logic [DATA_WIDTH-1:0] op_res;
  logic [DATA_WIDTH-1:0] acc_step;

  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign ALUResult = result_q;
  assign Zero      = (result_q == '0);

  assign shamt    = SrcB[SW-1:0];
  assign is_shift = (Operation == 4'b0111) || (Operation == 4'b1001) ||
                    (Operation == 4'b1010);
  assign lt_s     = $signed(SrcA) < $signed(SrcB);

  // Single-cycle ops; shift codes never use this value.
  always_comb begin
    op_res = '0;
    case (Operation)
      4'b0000: op_res = SrcA & SrcB;
      4'b0001: op_res = SrcA | SrcB;
      4'b0010: op_res = SrcA + SrcB;
      4'b0011: op_res = SrcA - SrcB;
      4'b0100: op_res = SrcA ^ SrcB;
      4'b0101: op_res = DATA_WIDTH'(lt_s);
      4'b0110: op_res = SrcB;
      4'b1000: op_res = DATA_WIDTH'(SrcA == SrcB);
      4'b1100: op_res = DATA_WIDTH'(lt_s);
      4'b1111: op_res = DATA_WIDTH'(!lt_s);
      default: op_res = '0;
    endcase
  end

  always_comb begin
    acc_step = acc_q;
    case (kind_q)
      K_SLL:   acc_step = {acc_q[DATA_WIDTH-2:0], 1'b0};
      K_SRL:   acc_step = {1'b0, acc_q[DATA_WIDTH-1:1]};
      K_SRA:   acc_step = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (flush) begin
      // A pending result is simply abandoned; out_valid drops with the state.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_shift) begin
              acc_d = SrcA;
              cnt_d = shamt;
              case (Operation)
                4'b1001: kind_d = K_SLL;
                4'b0111: kind_d = K_SRL;
                default: kind_d = K_SRA;
              endcase
              if (shamt == '0) begin
                result_d = SrcA;
                state_d  = S_DONE;
              end else begin
                state_d  = S_SHIFT;
              end
            end else begin
              result_d = op_res;
              state_d  = S_DONE;
            end
          end
        end
        S_SHIFT: begin
          acc_d = acc_step;
          cnt_d = cnt_q - SW'(1);
          if (cnt_q == SW'(1)) begin
            result_d = acc_step;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_SLL;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
module tb_alu_iter_exec;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, Zero, busy;
  logic [3:0]  Operation;
  logic [31:0] SrcA, SrcB, ALUResult;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_iter_exec #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
    .Zero(Zero), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: what the op means, straight from the op table.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return a - b;
      4'h4: return a ^ b;
      4'h5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h6: return b;
      4'h7: return a >> sh;
      4'h9: return a << sh;
      4'hA: return 32'($signed(a) >>> sh);
      4'h8: return (a == b) ? 32'd1 : 32'd0;
      4'hC: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hF: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'h7 || op == 4'h9 || op == 4'hA) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic accept_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    // Scramble inputs: the in-flight op must ignore them.
    Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  // Waits for out_valid; returns latency in cycles after the accept edge.
  task automatic wait_valid(output int lat);
    logic stall_bad;
    stall_bad = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && (in_ready || !busy)) stall_bad = 1'b1;
    end while (!out_valid && lat < 100);
    check("stall_ready_busy", 32'(stall_bad), 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    accept_op(op, a, b);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, ALUResult, exp);
    check({tag, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
  endtask

  initial begin
    int lat;
    int never_valid;
    logic [31:0] held;
    logic [3:0] op;
    logic [31:0] a, b;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Operation = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", 32'(Zero), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Directed ops
    do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
    do_op("sub_zero", 4'b0011, 32'd5, 32'd5, 32'd0, 1);
    do_op("lt_neg", 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    do_op("ge_neg", 4'b1111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    do_op("slt_eq", 4'b0101, 32'd3, 32'd3, 32'd0, 1);
    do_op("eq", 4'b1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1, 1);
    do_op("sra31", 4'b1010, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
    do_op("srl31", 4'b0111, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
    do_op("sll0", 4'b1001, 32'd1, 32'd0, 32'd1, 1);
    do_op("sll1", 4'b1001, 32'h8000_0001, 32'd1, 32'h0000_0002, 2);
    do_op("undef", 4'b1101, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1);

    // Backpressure
    @(negedge clk);
    out_ready = 1'b0;
    accept_op(4'b0100, 32'hF0F0_1234, 32'h0FF0_4321);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd1);
    held = ALUResult;
    check("bp_res", held, 32'hFF00_5115);
    for (int i = 0; i < 5; i++) begin
      SrcA = $urandom; SrcB = $urandom;
      @(negedge clk);
      check("bp_hold_res", ALUResult, held);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);

    // Flush mid-shift with a concurrent op offered
    accept_op(4'b1001, 32'h0000_00FF, 32'd10);
    repeat (3) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd2;
    #1;
    check("flush_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    never_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid || busy) never_valid++;
    end
    check("flush_no_result", 32'(never_valid), 32'd0);

    // Reset during SHIFT
    accept_op(4'b1010, 32'h8000_0000, 32'd20);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_shift_valid", 32'(out_valid), 32'd0);
    check("rst_shift_res", ALUResult, 32'd0);
    check("rst_shift_zero", 32'(Zero), 32'd1);
    check("rst_shift_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Reset during DONE
    out_ready = 1'b0;
    accept_op(4'b0001, 32'h00F0_0000, 32'h0000_000F);
    wait_valid(lat);
    check("pre_rst_done_res", ALUResult, 32'h00F0_000F);
    reset = 1'b0;
    @(negedge clk);
    check("rst_done_valid", 32'(out_valid), 32'd0);
    check("rst_done_res", ALUResult, 32'd0);
    check("rst_done_zero", 32'(Zero), 32'd1);
    check("rst_done_busy", 32'(busy), 32'd0);
    reset = 1'b1; out_ready = 1'b1;
    do_op("post_rst", 4'b1001, 32'h0000_0003, 32'd4, 32'h0000_0030, 5);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = a;
      do_op("rand", op, a, b, ref_alu(op, a, b), ref_lat(op, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage ALU that sits directly downstream of the ALU controller. It consumes the controller's 4-bit Operation code together with both operands, and produces ALUResult and Zero.
- Non-shift operations take a single cycle. Shifts are iterative, one bit per cycle, to save area.
- A valid/ready handshake on both sides lets the pipeline stall while a shift is in progress.

Parameters:
- DATA_WIDTH, 32, operand and result width. Shift-amount width SW = $clog2(DATA_WIDTH), derived internally.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; clears state on a rising clk edge while low.
- flush  in  1  kills any in-flight op (branch mispredict/trap).
- in_valid  in  1  operands and Operation valid.
- in_ready  out  1  block can accept an op this cycle.
- Operation  in  4  ALU op code from the controller.
- SrcA  in  DATA_WIDTH  operand A (rs1/PC).
- SrcB  in  DATA_WIDTH  operand B (rs2/imm); SrcB[SW-1:0] is the shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- ALUResult  out  DATA_WIDTH  registered result.
- Zero  out  1  ALUResult == 0.
- busy  out  1  state != IDLE, for the hazard unit.

Behaviour:
- Op encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB (A-B, wrap mod 2^DATA_WIDTH); 0100 XOR.
  - 0101 SLT (signed A<B, result 1/0); 0110 PASS B (LUI).
  - 0111 SRL; 1001 SLL; 1010 SRA.
  - 1000 EQ (A==B, 1/0); 1100 LT (signed, 1/0); 1111 GE (signed A>=B, 1/0).
  - All other codes: result 0, 1-cycle latency.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) && !flush. An accept occurs when in_valid && in_ready.
- IDLE, accept of a non-shift op: result is registered, go to DONE. Latency is 1 cycle, i.e. out_valid is high in the cycle after the accept.
- IDLE, accept of a shift with shamt N:
  - Load acc=SrcA and cnt=N; latch the shift kind.
  - N==0: go to DONE with ALUResult=SrcA (latency 1).
  - N>0: go to SHIFT.
- SHIFT: each cycle acc shifts by one bit and cnt decrements.
  - SLL fills 0 at the LSB; SRL fills 0 at the MSB; SRA replicates the MSB.
  - When cnt==1, the final shifted value is loaded into ALUResult and the state goes to DONE.
  - Latency is N+1 cycles; worst case is DATA_WIDTH for N=DATA_WIDTH-1.
- DONE: out_valid=1. ALUResult and Zero are held stable until out_ready.
  - out_valid && out_ready: return to IDLE. A new accept is possible the following cycle; there is no same-cycle re-accept.
- Zero is combinational from the registered ALUResult. It is valid only when out_valid=1.
- Inputs are sampled only at accept. Changes to SrcA, SrcB or Operation afterwards have no effect on the in-flight op.
- flush has priority over all events:
  - next state is IDLE and out_valid=0 the next cycle;
  - a result pending in DONE is discarded;
  - in_valid in the same cycle as flush is not accepted.
- Reset (reset==0 at a clk edge):
  - state=IDLE, out_valid=0, ALUResult=0, acc=0, cnt=0;
  - so Zero=1 and busy=0; in_ready=1 once reset is released.
  - Applies mid-shift or in DONE identically.
- Reset has priority over flush.

Test Plan:
- ADD and SUB:
  - Op 0010, A=32'h7FFF_FFFF, B=1 -> out_valid one cycle after accept, ALUResult=32'h8000_0000, Zero=0.
  - Op 0011, A=5, B=5 -> ALUResult=0, Zero=1.
- Signed compares:
  - Op 1100, A=32'hFFFF_FFFF, B=1 -> ALUResult=1.
  - Op 1111 with the same operands -> 0.
  - Op 0101, A=3, B=3 -> 0.
  - Op 1000, A=B=32'hDEAD_BEEF -> 1.
- Iterative shifts:
  - Op 1010, A=32'h8000_0000, B=31 -> out_valid exactly 32 cycles after accept, ALUResult=32'hFFFF_FFFF; in_ready=0 and busy=1 throughout.
  - Op 0111 with the same operands -> 32'h0000_0001.
  - Op 1001, A=1, B=0 -> ALUResult=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggling SrcA/SrcB -> ALUResult stays constant and in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- Flush mid-shift: SLL with shamt 10, flush asserted on cycle 4 together with in_valid=1 -> no out_valid ever for that op, in_ready=1 the following cycle, the concurrent op is not accepted.
- Reset mid-operation: reset low during SHIFT and again during DONE -> next edge out_valid=0, ALUResult=0, Zero=1, busy=0; an op issued after release completes normally. An undefined op (1101) -> ALUResult=0, latency 1.
